// File: rtl/tank_pkg.sv
// tank_pkg -- shared types and constants for the tank game slice.
//   dir_t          : tank / bullet facing (00 up, 01 down, 10 left, 11 right)
//   COL_*          : collision-detector result codes (COL_NONE = nothing hit)
//   SCREEN_W/H     : visible VGA area in pixels
//   PARK_POS       : off-screen coordinate used for an inactive bullet
//   bullet_state_t : bullet engine FSM states
//   reverse_dir    : opposite facing along the same axis
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam logic [2:0] COL_TOP    = 3'b000;
  localparam logic [2:0] COL_BOTTOM = 3'b001;
  localparam logic [2:0] COL_LEFT   = 3'b010;
  localparam logic [2:0] COL_RIGHT  = 3'b011;
  localparam logic [2:0] COL_NONE   = 3'b100;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [9:0] PARK_POS = 10'd1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FLIGHT   = 2'b01,
    ST_COOLDOWN = 2'b10
  } bullet_state_t;

  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect -- synchronous rising-edge pulse generator.
//   clk   : sampling clock
//   rst   : synchronous active-high reset, clears all three flops
//   din   : asynchronous level input
//   pulse : one-clk pulse per rising edge of din (two-flop synchroniser
//           followed by an edge register)
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/bullet_engine.sv
// bullet_engine -- single-bullet controller for one tank.
//   Clk, Reset              : system clock, synchronous active-high reset
//   frame_clk               : vsync-rate clock, edge-detected into frame_tick
//   fire                    : fire key level; one shot per press
//   dir                     : tank facing at the moment of firing
//   TankX/Y, TankSx/Sy      : owning tank geometry
//   disappear               : bullet-vs-obstacle code (COL_NONE = clear)
//   tank_bullet             : bullet-vs-enemy code (COL_NONE = clear)
//   DrawX, DrawY            : current VGA pixel
//   BulletX/Y, BulletSx/Sy  : bullet geometry (parked at 1000 when inactive)
//   bullet_active           : bullet in flight
//   hit_pulse               : one-Clk pulse when the enemy tank is struck
//   bullet_on               : DrawX/DrawY lies on the active bullet
// Optional feature: define BULLET_BOUNCE_EN to let a bullet bounce off the
// screen edge up to two times before a wall contact kills it.
module bullet_engine
  import tank_pkg::*;
#(
  parameter int unsigned BULLET_SIZE     = 4,
  parameter int unsigned BULLET_STEP     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [1:0] dir,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankSx,
  input  logic [9:0] TankSy,
  input  logic [2:0] disappear,
  input  logic [2:0] tank_bullet,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletSx,
  output logic [9:0] BulletSy,
  output logic       bullet_active,
  output logic       hit_pulse,
  output logic       bullet_on
);

  localparam int unsigned CW = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES);
  localparam logic [10:0]   SZ   = 11'(BULLET_SIZE);
  localparam logic [10:0]   HALF = 11'(BULLET_SIZE / 2);
  localparam logic [10:0]   ST   = 11'(BULLET_STEP);
  localparam logic [10:0]   XMAX = 11'(SCREEN_W - 1);
  localparam logic [10:0]   YMAX = 11'(SCREEN_H - 1);

  logic frame_tick;
  logic fire_req;

  edge_detect u_frame_edge (
    .clk   (Clk),
    .rst   (Reset),
    .din   (frame_clk),
    .pulse (frame_tick)
  );

  edge_detect u_fire_edge (
    .clk   (Clk),
    .rst   (Reset),
    .din   (fire),
    .pulse (fire_req)
  );

  bullet_state_t state_q, state_n;
  dir_t          dir_q, dir_n;
  logic [9:0]    x_q, x_n, y_q, y_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          active_q, active_n;
  logic          hit_q, hit_n;
`ifdef BULLET_BOUNCE_EN
  logic [1:0]    bounce_q, bounce_n;
`endif

  // Spawn point, 11 bits wide; each subtraction is guarded by its bound
  // check so a tank hugging the top/left edge never wraps.
  logic [10:0] tx, ty, tsx, tsy, cx, cy;
  logic [10:0] spawn_x, spawn_y;
  logic        spawn_ok;

  always_comb begin
    tx  = {1'b0, TankX};
    ty  = {1'b0, TankY};
    tsx = {1'b0, TankSx};
    tsy = {1'b0, TankSy};
    cx  = tx + (tsx >> 1);
    cy  = ty + (tsy >> 1);
    spawn_x  = '0;
    spawn_y  = '0;
    spawn_ok = 1'b1;
    unique case (dir_t'(dir))
      DIR_UP, DIR_DOWN: begin
        if (cx >= HALF) spawn_x = cx - HALF;
        else            spawn_ok = 1'b0;
        if (dir_t'(dir) == DIR_UP) begin
          if (ty >= SZ + 11'd1) spawn_y = ty - SZ - 11'd1;
          else                  spawn_ok = 1'b0;
        end else begin
          spawn_y = ty + tsy + 11'd1;
        end
      end
      default: begin
        if (cy >= HALF) spawn_y = cy - HALF;
        else            spawn_ok = 1'b0;
        if (dir_t'(dir) == DIR_LEFT) begin
          if (tx >= SZ + 11'd1) spawn_x = tx - SZ - 11'd1;
          else                  spawn_ok = 1'b0;
        end else begin
          spawn_x = tx + tsx + 11'd1;
        end
      end
    endcase
    if (spawn_x > XMAX || spawn_y > YMAX) spawn_ok = 1'b0;
  end

  // Wall test for the next step along the latched direction, plus the
  // stepped position (only used when the wall test is clear).
  logic [10:0] bx, by;
  logic        wall;
  logic [9:0]  step_x, step_y;

  always_comb begin
    bx     = {1'b0, x_q};
    by     = {1'b0, y_q};
    wall   = 1'b0;
    step_x = x_q;
    step_y = y_q;
    unique case (dir_q)
      DIR_UP: begin
        wall   = by < ST;
        step_y = y_q - 10'(BULLET_STEP);
      end
      DIR_DOWN: begin
        wall   = (by + ST + SZ) > YMAX;
        step_y = y_q + 10'(BULLET_STEP);
      end
      DIR_LEFT: begin
        wall   = bx < ST;
        step_x = x_q - 10'(BULLET_STEP);
      end
      default: begin
        wall   = (bx + ST + SZ) > XMAX;
        step_x = x_q + 10'(BULLET_STEP);
      end
    endcase
  end

  logic kill;

  always_comb begin
    state_n  = state_q;
    dir_n    = dir_q;
    x_n      = x_q;
    y_n      = y_q;
    cnt_n    = cnt_q;
    active_n = active_q;
    hit_n    = 1'b0;
    kill     = 1'b0;
`ifdef BULLET_BOUNCE_EN
    bounce_n = bounce_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (fire_req) begin
          dir_n = dir_t'(dir);
          if (spawn_ok) begin
            state_n  = ST_FLIGHT;
            x_n      = spawn_x[9:0];
            y_n      = spawn_y[9:0];
            active_n = 1'b1;
`ifdef BULLET_BOUNCE_EN
            bounce_n = '0;
`endif
          end else begin
            state_n = ST_COOLDOWN;
            cnt_n   = COOL_LOAD;
          end
        end
      end
      ST_FLIGHT: begin
        if (frame_tick) begin
          if (tank_bullet != COL_NONE) begin
            kill  = 1'b1;
            hit_n = 1'b1;
          end else if (disappear != COL_NONE) begin
            kill = 1'b1;
          end else if (wall) begin
`ifdef BULLET_BOUNCE_EN
            // Bounce keeps the bullet in place this tick; it moves the
            // opposite way on the next one.
            if (bounce_q < 2'd2) begin
              dir_n    = reverse_dir(dir_q);
              bounce_n = bounce_q + 2'd1;
            end else begin
              kill = 1'b1;
            end
`else
            kill = 1'b1;
`endif
          end else begin
            x_n = step_x;
            y_n = step_y;
          end
          if (kill) begin
            state_n  = ST_COOLDOWN;
            cnt_n    = COOL_LOAD;
            x_n      = PARK_POS;
            y_n      = PARK_POS;
            active_n = 1'b0;
          end
        end
      end
      ST_COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_q <= CW'(1)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      x_q      <= PARK_POS;
      y_q      <= PARK_POS;
      cnt_q    <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
`ifdef BULLET_BOUNCE_EN
      bounce_q <= '0;
`endif
    end else begin
      state_q  <= state_n;
      dir_q    <= dir_n;
      x_q      <= x_n;
      y_q      <= y_n;
      cnt_q    <= cnt_n;
      active_q <= active_n;
      hit_q    <= hit_n;
`ifdef BULLET_BOUNCE_EN
      bounce_q <= bounce_n;
`endif
    end
  end

  assign BulletX       = x_q;
  assign BulletY       = y_q;
  assign BulletSx      = 10'(BULLET_SIZE);
  assign BulletSy      = 10'(BULLET_SIZE);
  assign bullet_active = active_q;
  assign hit_pulse     = hit_q;

  assign bullet_on = active_q &&
                     ({1'b0, DrawX} >= bx) && ({1'b0, DrawX} <= bx + SZ) &&
                     ({1'b0, DrawY} >= by) && ({1'b0, DrawY} <= by + SZ);

endmodule

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine -- directed self-checking bench for bullet_engine.
// Honours BULLET_BOUNCE_EN the same way as the design.
module tb_bullet_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       fire;
  logic [1:0] dir;
  logic [9:0] TankX, TankY, TankSx, TankSy;
  logic [2:0] disappear, tank_bullet;
  logic [9:0] DrawX, DrawY;
  logic [9:0] BulletX, BulletY, BulletSx, BulletSy;
  logic       bullet_active, hit_pulse, bullet_on;

  bullet_engine #(
    .BULLET_SIZE     (4),
    .BULLET_STEP     (4),
    .COOLDOWN_FRAMES (15)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .fire          (fire),
    .dir           (dir),
    .TankX         (TankX),
    .TankY         (TankY),
    .TankSx        (TankSx),
    .TankSy        (TankSy),
    .disappear     (disappear),
    .tank_bullet   (tank_bullet),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .BulletX       (BulletX),
    .BulletY       (BulletY),
    .BulletSx      (BulletSx),
    .BulletSy      (BulletSy),
    .bullet_active (bullet_active),
    .hit_pulse     (hit_pulse),
    .bullet_on     (bullet_on)
  );

  always #5 Clk = ~Clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned hit_cnt = 0;
  int unsigned act_rises = 0;
  logic        prev_act = 1'b0;

  // Per-cycle monitor, sampled 1 time unit after the active edge.
  always @(posedge Clk) begin
    #1;
    if (hit_pulse === 1'b1) hit_cnt++;
    if (bullet_active === 1'b1 && prev_act === 1'b0) act_rises++;
    prev_act = bullet_active;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frame_pulse();
    frame_clk = 1'b1;
    step(4);
    frame_clk = 1'b0;
    step(4);
  endtask

  task automatic frames(input int unsigned n);
    repeat (n) frame_pulse();
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    step(4);
    fire = 1'b0;
    step(4);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    step(1);
  endtask

  task automatic set_tank(input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] sx, input logic [9:0] sy,
                          input logic [1:0] d);
    TankX = x; TankY = y; TankSx = sx; TankSy = sy; dir = d;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  int unsigned h0;
  int unsigned r0;
  logic [9:0]  last_x;

  initial begin
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0;
    set_tank(10'd300, 10'd300, 10'd30, 10'd30, 2'b11);
    disappear = 3'b100; tank_bullet = 3'b100;
    DrawX = '0; DrawY = '0;
    step(3);
    Reset = 1'b0;
    step(1);

    check("rst_active", bullet_active, 0);
    check("rst_x", BulletX, 1000);
    check("rst_y", BulletY, 1000);
    check("rst_hit", hit_pulse, 0);
    check("rst_sx", BulletSx, 4);
    check("rst_sy", BulletSy, 4);
    check("rst_on", bullet_on, 0);

    // Rightward spawn from a 30x30 tank at (300,300).
    fire_pulse();
    check("spawn_active", bullet_active, 1);
    check("spawn_x", BulletX, 331);
    check("spawn_y", BulletY, 313);
    DrawX = 10'd335; DrawY = 10'd317; #1;
    check("on_corner", bullet_on, 1);
    DrawX = 10'd336; #1;
    check("on_outside", bullet_on, 0);
    frame_pulse();
    check("step1_x", BulletX, 335);
    check("step1_y", BulletY, 313);

    // Enemy hit.
    h0 = hit_cnt;
    tank_bullet = 3'b010;
    frame_pulse();
    tank_bullet = 3'b100;
    check("hit_cycles", hit_cnt - h0, 1);
    check("hit_active", bullet_active, 0);
    check("hit_park_x", BulletX, 1000);
    check("hit_park_y", BulletY, 1000);

    // Cooldown: refire ignored at 5 and 14 ticks, accepted after 15.
    frames(5);
    fire_pulse();
    check("cool5_ignored", bullet_active, 0);
    frames(9);
    fire_pulse();
    check("cool14_ignored", bullet_active, 0);
    frames(1);
    fire_pulse();
    check("cool15_spawn", bullet_active, 1);
    check("cool15_x", BulletX, 331);

    // tank_bullet outranks disappear on the same tick.
    h0 = hit_cnt;
    disappear = 3'b000; tank_bullet = 3'b001;
    frame_pulse();
    disappear = 3'b100; tank_bullet = 3'b100;
    check("prio_hit", hit_cnt - h0, 1);
    check("prio_active", bullet_active, 0);

    // Obstacle kill without hit.
    frames(15);
    fire_pulse();
    check("obs_spawn", bullet_active, 1);
    h0 = hit_cnt;
    disappear = 3'b000;
    frame_pulse();
    disappear = 3'b100;
    check("obs_nohit", hit_cnt - h0, 0);
    check("obs_active", bullet_active, 0);
    check("obs_park", BulletX, 1000);

    // Reset mid-COOLDOWN clears the counter: immediate refire works.
    do_reset();
    fire_pulse();
    check("rst_cool_refire", bullet_active, 1);

    // Reset mid-FLIGHT.
    frame_pulse();
    check("pre_rst_x", BulletX, 335);
    Reset = 1'b1;
    step(1);
    check("rstf_active", bullet_active, 0);
    check("rstf_x", BulletX, 1000);
    check("rstf_y", BulletY, 1000);
    check("rstf_hit", hit_pulse, 0);
    Reset = 1'b0;
    step(1);

    // Up from TankY=2: no spawn, cooldown entered.
    set_tank(10'd300, 10'd2, 10'd30, 10'd30, 2'b00);
    fire_pulse();
    check("up_nospawn", bullet_active, 0);
    check("up_park_y", BulletY, 1000);
    dir = 2'b11; TankY = 10'd300;
    frame_pulse();
    fire_pulse();
    check("up_cooldown", bullet_active, 0);
    frames(14);
    fire_pulse();
    check("up_after_cool", bullet_active, 1);

    // Fire held for 100 frames: one shot only.
    do_reset();
    set_tank(10'd300, 10'd300, 10'd30, 10'd30, 2'b11);
    r0 = act_rises;
    fire = 1'b1;
    frames(100);
    fire = 1'b0;
    step(4);
    check("hold_one_shot", act_rises - r0, 1);

    // Right wall.
    do_reset();
    set_tank(10'd600, 10'd300, 10'd27, 10'd30, 2'b11);
    fire_pulse();
    check("wall_spawn_x", BulletX, 628);
    frame_pulse();
    check("wall_632", BulletX, 632);
    frame_pulse();
`ifdef BULLET_BOUNCE_EN
    check("bounce1_active", bullet_active, 1);
    check("bounce1_x", BulletX, 632);
    frame_pulse();
    check("bounce1_left", BulletX, 628);
    for (int i = 0; i < 200 && BulletX != 10'd0; i++) frame_pulse();
    check("bounce_reach0", BulletX, 0);
    frame_pulse();
    check("bounce2_x", BulletX, 0);
    check("bounce2_active", bullet_active, 1);
    frame_pulse();
    check("bounce2_right", BulletX, 4);
    last_x = BulletX;
    for (int i = 0; i < 200 && bullet_active; i++) begin
      last_x = BulletX;
      frame_pulse();
    end
    check("third_kill", bullet_active, 0);
    check("third_kill_x", last_x, 632);
`else
    check("wall_kill_active", bullet_active, 0);
    check("wall_kill_x", BulletX, 1000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
